// File: rtl/map_sst_seq_if.sv
// ============================================================================
// Module   : map_sst_seq_if
// Brief    : Interface bundle for the save-state sequencer: control, sst
//            register bus and the SAVE/LOAD byte streams.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface map_sst_seq_if;
  // control
  logic       start_save;
  logic       start_load;
  logic       abort;
  logic       busy;
  logic       done;
  logic       slot;
  // sst register bus
  logic       sst_act;
  logic [7:0] sst_addr;
  logic       sst_we_reg;
  logic [7:0] sst_dato;
  logic [7:0] sst_di;
  // SAVE stream
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  // LOAD stream
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  // sequencer side
  modport master (
    input  start_save, start_load, abort, slot, sst_di, out_ready, in_data, in_valid,
    output busy, done, sst_act, sst_addr, sst_we_reg, sst_dato, out_data, out_valid, in_ready
  );

  // environment side (mapper core, stream endpoints, control)
  modport slave (
    output start_save, start_load, abort, slot, sst_di, out_ready, in_data, in_valid,
    input  busy, done, sst_act, sst_addr, sst_we_reg, sst_dato, out_data, out_valid, in_ready
  );
endinterface

`default_nettype wire

// File: rtl/map_sst_seq.sv
// ============================================================================
// Module   : map_sst_seq
// Brief    : Save-state sequencer for mapper register files. Walks register
//            indices 0..REG_COUNT-1; SAVE reads and streams each register out,
//            LOAD takes a byte stream and writes each register in a CPU
//            write slot.
// Revision : 1.0
// ============================================================================
`default_nettype none

module map_sst_seq #(
  parameter int REG_COUNT = 11,  // 2..256
  parameter int RD_LAT    = 2    // 1..7
) (
  input  logic          clk,
  input  logic          map_rst_n,
  map_sst_seq_if.master bus
);

  localparam int              IDX_W      = $clog2(REG_COUNT);
  localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(REG_COUNT - 1);
  localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);
  localparam logic [2:0]       c_RD_LAST  = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_S_RD   = 3'd1,
    ST_S_PUSH = 3'd2,
    ST_L_PULL = 3'd3,
    ST_L_SLOT = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       rd_cnt_q, rd_cnt_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic [7:0]       wr_data_q, wr_data_d;

  logic w_last;
  logic w_owned;
  logic w_abort;

  assign w_last  = (idx_q == c_IDX_LAST);
  assign w_owned = (state_q == ST_S_RD)   || (state_q == ST_S_PUSH) ||
                   (state_q == ST_L_PULL) || (state_q == ST_L_SLOT);
  // FINISH is also cancellable; it simply returns to IDLE either way
  assign w_abort = bus.abort && (state_q != ST_IDLE);

  // State and datapath registers; async reset drops bus ownership at once
  always_ff @(posedge clk or negedge map_rst_n) begin
    if (!map_rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      rd_cnt_q  <= '0;
      rd_data_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_data_q <= rd_data_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Next-state logic for the SAVE/LOAD walk
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rd_cnt_d  = rd_cnt_q;
    rd_data_d = rd_data_q;
    wr_data_d = wr_data_q;

    if (w_abort) begin
      state_d  = ST_IDLE;
      idx_d    = '0;
      rd_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          idx_d    = '0;
          rd_cnt_d = '0;
          // SAVE has priority when both requests arrive together
          if (bus.start_save) begin
            state_d = ST_S_RD;
          end else if (bus.start_load) begin
            state_d = ST_L_PULL;
          end
        end
        ST_S_RD: begin
          // address is held for RD_LAT cycles; read data is valid on the last one
          if (rd_cnt_q == c_RD_LAST) begin
            rd_data_d = bus.sst_di;
            rd_cnt_d  = '0;
            state_d   = ST_S_PUSH;
          end else begin
            rd_cnt_d = rd_cnt_q + 3'd1;
          end
        end
        ST_S_PUSH: begin
          if (bus.out_ready) begin
            if (w_last) begin
              state_d = ST_FINISH;
            end else begin
              idx_d   = idx_q + c_IDX_ONE;
              state_d = ST_S_RD;
            end
          end
        end
        ST_L_PULL: begin
          if (bus.in_valid) begin
            wr_data_d = bus.in_data;
            state_d   = ST_L_SLOT;
          end
        end
        ST_L_SLOT: begin
          // a slot coinciding with the input handshake is seen in L_PULL and ignored
          if (bus.slot) begin
            if (w_last) begin
              state_d = ST_FINISH;
            end else begin
              idx_d   = idx_q + c_IDX_ONE;
              state_d = ST_L_PULL;
            end
          end
        end
        ST_FINISH: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Moore outputs decoded from the state register; the register write strobe
  // follows the slot pulse and is masked by abort
  assign bus.busy       = w_owned;
  assign bus.sst_act    = w_owned;
  assign bus.done       = (state_q == ST_FINISH);
  assign bus.sst_addr   = w_owned ? 8'(idx_q) : 8'h00;
  assign bus.sst_we_reg = (state_q == ST_L_SLOT) && bus.slot && !bus.abort;
  assign bus.sst_dato   = (state_q == ST_L_SLOT) ? wr_data_q : 8'h00;
  assign bus.out_valid  = (state_q == ST_S_PUSH);
  assign bus.out_data   = (state_q == ST_S_PUSH) ? rd_data_q : 8'h00;
  assign bus.in_ready   = (state_q == ST_L_PULL);

endmodule

`default_nettype wire

// File: tb/tb_map_sst_seq.sv
// ============================================================================
// Module   : tb_map_sst_seq
// Brief    : Directed self-checking bench for map_sst_seq with a queue
//            scoreboard for the SAVE stream and the register write strobes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_map_sst_seq;

  localparam int REG_COUNT = 11;
  localparam int RD_LAT    = 2;

  logic clk       = 1'b0;
  logic map_rst_n = 1'b0;
  always #5 clk = ~clk;

  map_sst_seq_if bus ();

  map_sst_seq #(.REG_COUNT(REG_COUNT), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .map_rst_n (map_rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;

  // free-running cycle counter for slot / out_ready patterns
  int   cyc      = 0;
  logic slot_en  = 1'b0;
  logic slot_man = 1'b0;
  logic tog_en   = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus.slot      = (slot_en && (cyc % 4 == 3)) || slot_man;
  assign bus.out_ready = tog_en ? (cyc % 3 == 0) : 1'b1;

  // mapper model: one register stage, so data for an address presented in
  // read cycle 1 is valid in read cycle RD_LAT (=2)
  logic [7:0] di_q = 8'h00;
  always @(posedge clk) di_q <= bus.sst_addr ^ 8'hA5;
  assign bus.sst_di = di_q;

  logic [7:0]  save_q[$];
  logic [15:0] load_q[$];
  int   we_cnt        = 0;
  int   done_cnt      = 0;
  logic in_ready_seen = 1'b0;
  logic hold_v        = 1'b0;
  logic [7:0] hold_d  = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // output monitor / scoreboard
  always @(negedge clk) begin
    if (map_rst_n) begin
      if (hold_v && bus.out_valid) chk("out_hold", bus.out_data, hold_d);
      hold_v = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        chk("save_expected", save_q.size() != 0, 1);
        if (save_q.size() != 0) chk("save_byte", bus.out_data, save_q.pop_front());
      end
      if (bus.sst_we_reg) begin
        we_cnt++;
        chk("we_slot", bus.slot, 1);
        chk("we_expected", load_q.size() != 0, 1);
        if (load_q.size() != 0) chk("we_addr_data", {bus.sst_addr, bus.sst_dato}, load_q.pop_front());
      end
      if (bus.in_ready) in_ready_seen = 1'b1;
      if (bus.done) done_cnt++;
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cycles from the start-request cycle to the done cycle (bounded)
  task automatic wait_done(input int limit, output int n);
    tick();
    n = 1;
    while (n < limit) begin
      @(negedge clk);
      if (bus.done) break;
      tick();
      n++;
    end
    chk("done_timeout", n < limit, 1);
  endtask

  task automatic push_save();
    for (int i = 0; i < REG_COUNT; i++) save_q.push_back(8'(i) ^ 8'hA5);
  endtask

  // present one byte and return just after its handshake edge
  task automatic load_one(input logic [7:0] d);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_timeout", n < 100, 1);
    tick();
  endtask

  initial begin
    int n;
    int d0;
    int w0;
    bus.start_save = 1'b0;
    bus.start_load = 1'b0;
    bus.abort      = 1'b0;
    bus.in_data    = 8'h00;
    bus.in_valid   = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1 map_rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_act", bus.sst_act, 0);
    chk("rst_addr", bus.sst_addr, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_we", bus.sst_we_reg, 0);
    tick();

    // 1: SAVE with out_ready tied high
    push_save();
    w0 = we_cnt;
    bus.start_save = 1'b1;
    tick();
    bus.start_save = 1'b0;
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      if (bus.done) break;
      tick();
      n++;
    end
    chk("save_latency", n, 34);
    tick();
    chk("save_q_empty", save_q.size(), 0);
    chk("save_no_we", we_cnt - w0, 0);
    chk("save_idle_busy", bus.busy, 0);

    // 2: LOAD 11 bytes, slot every 4th cycle
    for (int i = 0; i < REG_COUNT; i++) load_q.push_back({8'(i), 8'h10 + 8'(i)});
    w0 = we_cnt;
    d0 = done_cnt;
    slot_en = 1'b1;
    bus.start_load = 1'b1;
    tick();
    bus.start_load = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) load_one(8'h10 + 8'(i));
    bus.in_valid = 1'b0;
    wait_done(200, n);
    tick();
    slot_en = 1'b0;
    chk("load_we_count", we_cnt - w0, REG_COUNT);
    chk("load_q_empty", load_q.size(), 0);
    chk("load_done_count", done_cnt - d0, 1);

    // 3: SAVE with out_ready high one cycle in three
    push_save();
    tog_en = 1'b1;
    bus.start_save = 1'b1;
    tick();
    bus.start_save = 1'b0;
    wait_done(500, n);
    tick();
    tog_en = 1'b0;
    chk("toggle_q_empty", save_q.size(), 0);

    // 4: both starts together -> SAVE
    push_save();
    w0 = we_cnt;
    in_ready_seen = 1'b0;
    bus.start_save = 1'b1;
    bus.start_load = 1'b1;
    tick();
    bus.start_save = 1'b0;
    bus.start_load = 1'b0;
    wait_done(200, n);
    tick();
    chk("both_in_ready", in_ready_seen, 0);
    chk("both_q_empty", save_q.size(), 0);
    chk("both_no_we", we_cnt - w0, 0);

    // 5: abort in L_SLOT at idx 5 on a slot cycle
    d0 = done_cnt;
    w0 = we_cnt;
    bus.start_load = 1'b1;
    tick();
    bus.start_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_q.push_back({8'(i), 8'h30 + 8'(i)});
      load_one(8'h30 + 8'(i));
      bus.in_valid = 1'b0;
      slot_man = 1'b1;
      tick();
      slot_man = 1'b0;
    end
    load_one(8'h35);
    bus.in_valid = 1'b0;
    chk("abort_addr5", bus.sst_addr, 5);
    slot_man  = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    chk("abort_we_masked", bus.sst_we_reg, 0);
    tick();
    slot_man  = 1'b0;
    bus.abort = 1'b0;
    chk("abort_act", bus.sst_act, 0);
    chk("abort_busy", bus.busy, 0);
    repeat (4) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_we_count", we_cnt - w0, 5);
    // restart begins again at index 0
    load_q.push_back({8'h00, 8'h55});
    bus.start_load = 1'b1;
    tick();
    bus.start_load = 1'b0;
    load_one(8'h55);
    bus.in_valid = 1'b0;
    slot_man = 1'b1;
    tick();
    slot_man  = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("restart_we_count", we_cnt - w0, 6);
    chk("restart_q_empty", load_q.size(), 0);

    // 6: async reset mid-SAVE at idx 3
    push_save();
    d0 = done_cnt;
    bus.start_save = 1'b1;
    tick();
    bus.start_save = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(bus.sst_act && bus.sst_addr == 8'd3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reach_idx3", n < 100, 1);
    #1 map_rst_n = 1'b0;
    #1;
    chk("rst_mid_act", bus.sst_act, 0);
    chk("rst_mid_out_valid", bus.out_valid, 0);
    chk("rst_mid_busy", bus.busy, 0);
    save_q.delete();
    #1 map_rst_n = 1'b1;
    tick();
    chk("rst_mid_no_done", done_cnt - d0, 0);
    push_save();
    bus.start_save = 1'b1;
    tick();
    bus.start_save = 1'b0;
    wait_done(200, n);
    tick();
    chk("rst_restart_q_empty", save_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
